// File: rtl/cc_update_ctrl_pkg.sv
// Shared definitions for the Y86-64 condition-code controller.
// Holds icode/stat/ifun encodings, CC bit positions, the CC reset value
// and the controller state type.
package cc_update_ctrl_pkg;

  localparam int unsigned ICODE_W = 4;
  localparam int unsigned IFUN_W  = 4;
  localparam int unsigned STAT_W  = 3;
  localparam int unsigned CC_W    = 3;

  // Instruction codes the controller reacts to
  localparam logic [ICODE_W-1:0] IOPQ    = 4'h6;
  localparam logic [ICODE_W-1:0] IJXX    = 4'h7;
  localparam logic [ICODE_W-1:0] ICMOVXX = 4'h2;

  // Pipeline status codes
  localparam logic [STAT_W-1:0] SAOK = 3'd1;
  localparam logic [STAT_W-1:0] SHLT = 3'd2;
  localparam logic [STAT_W-1:0] SADR = 3'd3;
  localparam logic [STAT_W-1:0] SINS = 3'd4;

  // jXX / cmovXX condition selectors
  localparam logic [IFUN_W-1:0] C_YES = 4'd0;
  localparam logic [IFUN_W-1:0] C_LE  = 4'd1;
  localparam logic [IFUN_W-1:0] C_L   = 4'd2;
  localparam logic [IFUN_W-1:0] C_E   = 4'd3;
  localparam logic [IFUN_W-1:0] C_NE  = 4'd4;
  localparam logic [IFUN_W-1:0] C_GE  = 4'd5;
  localparam logic [IFUN_W-1:0] C_G   = 4'd6;

  // Bit positions inside the stored CC word
  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;

  // ZF set, SF/OF clear after reset
  localparam logic [CC_W-1:0] CC_RESET = 3'b100;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FROZEN = 1'b1
  } cc_state_t;

endpackage

// File: rtl/cc_update_ctrl_cond_eval.sv
// cc_cond_eval: purely combinational jXX/cmovXX condition evaluator.
// Ports:
//   cc   in  3  stored {ZF,SF,OF}
//   ifun in  4  condition selector
//   cnd  out 1  condition result (0 for undefined selectors 7..15)
module cc_cond_eval
  import cc_update_ctrl_pkg::*;
(
  input  logic [CC_W-1:0]   cc,
  input  logic [IFUN_W-1:0] ifun,
  output logic              cnd
);

  logic zf;
  logic lt;

  assign zf = cc[CC_ZF];
  // Signed less-than after a subtraction
  assign lt = cc[CC_SF] ^ cc[CC_OF];

  // Condition table lookup
  always_comb begin
    cnd = 1'b0;
    unique case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = lt | zf;
      C_L:     cnd = lt;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~lt;
      C_G:     cnd = ~lt & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_update_ctrl.sv
// cc_update_ctrl: execute-stage condition-code controller.
// Owns the CC register, gates ALU flag commits, freezes permanently after
// an exception reaches M or W, evaluates jXX/cmovXX conditions against the
// stored CC and pipelines the result into M.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   e_icode, e_ifun       E-stage instruction code / function
//   e_bubble              E stage holds a bubble
//   alu_zf/sf/of          ALU flags this cycle
//   m_stat, w_stat        M/W stage status
//   m_stall, m_bubble     M-stage cnd register control
//   cc                    stored {ZF,SF,OF}
//   e_cnd                 E-stage condition (combinational)
//   m_cnd                 M-stage copy of e_cnd
//   cc_set                commit strobe (combinational)
//   frozen                controller is in FROZEN
//   cc_write_cnt          saturating count of commits
module cc_update_ctrl
  import cc_update_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         e_icode,
  input  logic [3:0]         e_ifun,
  input  logic               e_bubble,
  input  logic               alu_zf,
  input  logic               alu_sf,
  input  logic               alu_of,
  input  logic [2:0]         m_stat,
  input  logic [2:0]         w_stat,
  input  logic               m_stall,
  input  logic               m_bubble,
  output logic [2:0]         cc,
  output logic               e_cnd,
  output logic               m_cnd,
  output logic               cc_set,
  output logic               frozen,
  output logic [CNT_W-1:0]   cc_write_cnt
);

  cc_state_t state;
  cc_state_t state_next;
  logic      stats_ok;
  logic      cond_raw;
  logic      is_cond_insn;

  assign stats_ok = (m_stat == SAOK) && (w_stat == SAOK);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: any non-AOK status in M or W freezes until reset
  always_comb begin
    state_next = state;
    unique case (state)
      ST_RUN:    if (!stats_ok) state_next = ST_FROZEN;
      ST_FROZEN: state_next = ST_FROZEN;
      default:   state_next = ST_RUN;
    endcase
  end

  // FSM outputs; the stats_ok term suppresses a commit in the exception cycle
  always_comb begin
    cc_set = 1'b0;
    frozen = 1'b0;
    unique case (state)
      ST_RUN:    cc_set = !e_bubble && (e_icode == IOPQ) && stats_ok;
      ST_FROZEN: frozen = 1'b1;
      default:   ;
    endcase
  end

  // CC storage
  always_ff @(posedge clk) begin
    if (reset) begin
      cc <= CC_RESET;
    end else if (cc_set) begin
      cc <= {alu_zf, alu_sf, alu_of};
    end
  end

  // Conditions use stored CC only; no bypass from the ALU flags
  cc_cond_eval u_cond_eval (
    .cc   (cc),
    .ifun (e_ifun),
    .cnd  (cond_raw)
  );

  assign is_cond_insn = (e_icode == ICMOVXX) || (e_icode == IJXX);
  assign e_cnd        = cond_raw && is_cond_insn && !e_bubble;

  // M-stage cnd register: bubble beats stall
  always_ff @(posedge clk) begin
    if (reset) begin
      m_cnd <= 1'b0;
    end else if (m_bubble) begin
      m_cnd <= 1'b0;
    end else if (!m_stall) begin
      m_cnd <= e_cnd;
    end
  end

  // Saturating commit counter, unaffected by FROZEN
  always_ff @(posedge clk) begin
    if (reset) begin
      cc_write_cnt <= '0;
    end else if (cc_set && (cc_write_cnt != {CNT_W{1'b1}})) begin
      cc_write_cnt <= cc_write_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cc_update_ctrl.sv
// Directed self-checking bench for cc_update_ctrl.
// A second instance with CNT_W=2 shares all inputs to check saturation.
module tb_cc_update_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  e_icode;
  logic [3:0]  e_ifun;
  logic        e_bubble;
  logic        alu_zf, alu_sf, alu_of;
  logic [2:0]  m_stat, w_stat;
  logic        m_stall, m_bubble;

  logic [2:0]  cc;
  logic        e_cnd, m_cnd, cc_set, frozen;
  logic [15:0] cc_write_cnt;

  logic [2:0]  cc2;
  logic        e_cnd2, m_cnd2, cc_set2, frozen2;
  logic [1:0]  cnt2;

  int checks;
  int errors;

  cc_update_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .e_icode(e_icode), .e_ifun(e_ifun),
    .e_bubble(e_bubble), .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
    .m_stat(m_stat), .w_stat(w_stat), .m_stall(m_stall), .m_bubble(m_bubble),
    .cc(cc), .e_cnd(e_cnd), .m_cnd(m_cnd), .cc_set(cc_set), .frozen(frozen),
    .cc_write_cnt(cc_write_cnt)
  );

  cc_update_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .e_icode(e_icode), .e_ifun(e_ifun),
    .e_bubble(e_bubble), .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
    .m_stat(m_stat), .w_stat(w_stat), .m_stall(m_stall), .m_bubble(m_bubble),
    .cc(cc2), .e_cnd(e_cnd2), .m_cnd(m_cnd2), .cc_set(cc_set2), .frozen(frozen2),
    .cc_write_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference for the condition table (ZF=bit2, SF=bit1, OF=bit0)
  function automatic logic ref_cond(input int c, input int f);
    logic z, s, o;
    z = c[2]; s = c[1]; o = c[0];
    case (f)
      0: return 1'b1;
      1: return (s != o) || z;
      2: return (s != o);
      3: return z;
      4: return !z;
      5: return (s == o);
      6: return (s == o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; e_icode = 4'h0; e_ifun = 4'h0; e_bubble = 1'b0;
    alu_zf = 1'b0; alu_sf = 1'b0; alu_of = 1'b0;
    m_stat = 3'd1; w_stat = 3'd1; m_stall = 1'b0; m_bubble = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL reset_cc got %b exp 100", cc); end
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL reset_frozen got %b exp 0", frozen); end
    checks++; if (m_cnd !== 1'b0) begin errors++; $display("FAIL reset_m_cnd got %b exp 0", m_cnd); end
    checks++; if (cc_write_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cc_write_cnt); end
    checks++; if (cc_set !== 1'b0) begin errors++; $display("FAIL reset_cc_set got %b exp 0", cc_set); end
  endtask

  task automatic test_opq_then_jxx();
    do_reset();
    e_icode = 4'h6; alu_zf = 1'b0; alu_sf = 1'b1; alu_of = 1'b0;
    #1;
    checks++; if (cc_set !== 1'b1) begin errors++; $display("FAIL opq_cc_set got %b exp 1", cc_set); end
    // Old flags still in use for a condition this cycle (ZF=1 -> e never applies: icode is OPq -> 0)
    checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL opq_e_cnd got %b exp 0", e_cnd); end
    step();
    checks++; if (cc !== 3'b010) begin errors++; $display("FAIL opq_cc got %b exp 010", cc); end
    checks++; if (cc_write_cnt !== 16'd1) begin errors++; $display("FAIL opq_cnt got %0d exp 1", cc_write_cnt); end
    e_icode = 4'h7; e_ifun = 4'd2; alu_sf = 1'b0;
    #1;
    checks++; if (e_cnd !== 1'b1) begin errors++; $display("FAIL jl_e_cnd got %b exp 1", e_cnd); end
    checks++; if (cc_set !== 1'b0) begin errors++; $display("FAIL jl_cc_set got %b exp 0", cc_set); end
    step();
    checks++; if (m_cnd !== 1'b1) begin errors++; $display("FAIL jl_m_cnd got %b exp 1", m_cnd); end
    checks++; if (cc !== 3'b010) begin errors++; $display("FAIL jl_cc_hold got %b exp 010", cc); end
    idle();
    step();
    checks++; if (m_cnd !== 1'b0) begin errors++; $display("FAIL idle_m_cnd got %b exp 0", m_cnd); end
  endtask

  task automatic test_exception();
    do_reset();
    e_icode = 4'h6; alu_zf = 1'b1; alu_sf = 1'b0; alu_of = 1'b0; m_stat = 3'd3;
    #1;
    checks++; if (cc_set !== 1'b0) begin errors++; $display("FAIL exc_cc_set got %b exp 0", cc_set); end
    step();
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL exc_cc got %b exp 100", cc); end
    checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL exc_frozen got %b exp 1", frozen); end
    m_stat = 3'd1; alu_zf = 1'b0; alu_sf = 1'b1; alu_of = 1'b1;
    #1;
    checks++; if (cc_set !== 1'b0) begin errors++; $display("FAIL frz_cc_set got %b exp 0", cc_set); end
    step();
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL frz_cc got %b exp 100", cc); end
    checks++; if (cc_write_cnt !== 16'd0) begin errors++; $display("FAIL frz_cnt got %0d exp 0", cc_write_cnt); end
    checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL frz_stays got %b exp 1", frozen); end
    // W-stage status alone also freezes
    do_reset();
    w_stat = 3'd2;
    step();
    checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL wstat_frozen got %b exp 1", frozen); end
  endtask

  task automatic test_reset_from_frozen();
    reset = 1'b1;
    step();
    idle();
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL unfrz_frozen got %b exp 0", frozen); end
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL unfrz_cc got %b exp 100", cc); end
    checks++; if (cc_write_cnt !== 16'd0) begin errors++; $display("FAIL unfrz_cnt got %0d exp 0", cc_write_cnt); end
    e_icode = 4'h6; alu_of = 1'b1;
    step();
    checks++; if (cc !== 3'b001) begin errors++; $display("FAIL unfrz_opq_cc got %b exp 001", cc); end
    checks++; if (cc_write_cnt !== 16'd1) begin errors++; $display("FAIL unfrz_opq_cnt got %0d exp 1", cc_write_cnt); end
  endtask

  task automatic test_cond_sweep();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      e_icode = 4'h6; e_bubble = 1'b0;
      {alu_zf, alu_sf, alu_of} = 3'(c);
      step();
      checks++; if (cc !== 3'(c)) begin errors++; $display("FAIL sweep_load_cc got %b exp %b", cc, 3'(c)); end
      e_icode = 4'h2;
      for (int f = 0; f < 16; f++) begin
        e_ifun = 4'(f);
        #1;
        checks++;
        if (e_cnd !== ref_cond(c, f)) begin
          errors++;
          $display("FAIL sweep_cc%0d_ifun%0d got %b exp %b", c, f, e_cnd, ref_cond(c, f));
        end
      end
      e_ifun = 4'd0; e_bubble = 1'b1;
      #1;
      checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL sweep_bubble_cc%0d got %b exp 0", c, e_cnd); end
      e_bubble = 1'b0; e_icode = 4'h6;
      #1;
      checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL sweep_opq_cc%0d got %b exp 0", c, e_cnd); end
    end
    idle();
  endtask

  task automatic test_m_cnd_ctrl();
    do_reset();
    e_icode = 4'h7; e_ifun = 4'd0; m_stall = 1'b1;
    #1;
    checks++; if (e_cnd !== 1'b1) begin errors++; $display("FAIL mctl_e_cnd got %b exp 1", e_cnd); end
    step();
    checks++; if (m_cnd !== 1'b0) begin errors++; $display("FAIL mctl_stall_hold0 got %b exp 0", m_cnd); end
    m_bubble = 1'b1;
    step();
    checks++; if (m_cnd !== 1'b0) begin errors++; $display("FAIL mctl_both got %b exp 0", m_cnd); end
    m_stall = 1'b0; m_bubble = 1'b0;
    step();
    checks++; if (m_cnd !== 1'b1) begin errors++; $display("FAIL mctl_release got %b exp 1", m_cnd); end
    e_icode = 4'h0; m_stall = 1'b1;
    step();
    checks++; if (m_cnd !== 1'b1) begin errors++; $display("FAIL mctl_stall_hold1 got %b exp 1", m_cnd); end
    m_bubble = 1'b1;
    step();
    checks++; if (m_cnd !== 1'b0) begin errors++; $display("FAIL mctl_bubble_wins got %b exp 0", m_cnd); end
    idle();
  endtask

  task automatic test_reset_priority();
    do_reset();
    e_icode = 4'h6; alu_sf = 1'b1;
    step();
    e_icode = 4'h7; e_ifun = 4'd0; alu_sf = 1'b0;
    step();
    checks++; if (m_cnd !== 1'b1) begin errors++; $display("FAIL rprio_pre_m_cnd got %b exp 1", m_cnd); end
    reset = 1'b1; e_icode = 4'h6; alu_zf = 1'b0; alu_sf = 1'b1; alu_of = 1'b1; m_stall = 1'b1;
    step();
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL rprio_cc got %b exp 100", cc); end
    checks++; if (m_cnd !== 1'b0) begin errors++; $display("FAIL rprio_m_cnd got %b exp 0", m_cnd); end
    checks++; if (cc_write_cnt !== 16'd0) begin errors++; $display("FAIL rprio_cnt got %0d exp 0", cc_write_cnt); end
    idle();
  endtask

  task automatic test_back_to_back_saturation();
    logic [1:0] exp_sat [5];
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3; exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
    do_reset();
    e_icode = 4'h6;
    for (int i = 0; i < 5; i++) begin
      {alu_zf, alu_sf, alu_of} = 3'(i);
      step();
      checks++;
      if (cnt2 !== exp_sat[i]) begin errors++; $display("FAIL sat_cnt2_%0d got %0d exp %0d", i, cnt2, exp_sat[i]); end
      checks++;
      if (cc_write_cnt !== 16'(i + 1)) begin errors++; $display("FAIL b2b_cnt_%0d got %0d exp %0d", i, cc_write_cnt, i + 1); end
      checks++;
      if (cc !== 3'(i)) begin errors++; $display("FAIL b2b_cc_%0d got %b exp %b", i, cc, 3'(i)); end
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    reset = 1'b1;
    test_reset();
    test_opq_then_jxx();
    test_exception();
    test_reset_from_frozen();
    test_cond_sweep();
    test_m_cnd_ctrl();
    test_reset_priority();
    test_back_to_back_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
